// File: rtl/zx_kbd_pkg.sv
// Shared types and constants for the PS/2 to ZX Spectrum keyboard matrix.
package zx_kbd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BRK     = 2'd1,
    EXT     = 2'd2,
    EXT_BRK = 2'd3
  } kbd_state_t;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BAT_OK = 8'hAA;
  localparam logic [7:0] SC_OVR_LO = 8'h00;
  localparam logic [7:0] SC_OVR_HI = 8'hFF;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

  localparam int ROWS     = 8;
  localparam int COLS     = 5;
  localparam int EXT_KEYS = 5;

  typedef struct packed {
    logic       valid;
    logic [2:0] row;
    logic [2:0] col;
    logic [2:0] ext_idx;
    logic       ext_valid;
  } key_pos_t;

  function automatic key_pos_t key_at(input logic [2:0] row, input logic [2:0] col);
    key_pos_t p;
    p       = '0;
    p.valid = 1'b1;
    p.row   = row;
    p.col   = col;
    return p;
  endfunction

  function automatic key_pos_t ext_key_at(input logic [2:0] row, input logic [2:0] col,
                                          input logic [2:0] idx);
    key_pos_t p;
    p           = key_at(row, col);
    p.ext_idx   = idx;
    p.ext_valid = 1'b1;
    return p;
  endfunction

endpackage

// File: rtl/ps2_zx_decode.sv
// Combinational lookup from {extended, scan code} to a Spectrum matrix position.
// Composite CAPS keys (arrows, Backspace) exist only when PS2_EXTENDED_KEYS_EN is defined.
module ps2_zx_decode
  import zx_kbd_pkg::*;
(
  input  logic       extended_i,
  input  logic [7:0] scan_code_i,
  output key_pos_t   pos_o
);

  always_comb begin
    pos_o = '0;
    case ({extended_i, scan_code_i})
      // row0 bit0 is CAPS and is derived, never decoded
      9'h01A: pos_o = key_at(3'd0, 3'd1);
      9'h022: pos_o = key_at(3'd0, 3'd2);
      9'h021: pos_o = key_at(3'd0, 3'd3);
      9'h02A: pos_o = key_at(3'd0, 3'd4);
      9'h01C: pos_o = key_at(3'd1, 3'd0);
      9'h01B: pos_o = key_at(3'd1, 3'd1);
      9'h023: pos_o = key_at(3'd1, 3'd2);
      9'h02B: pos_o = key_at(3'd1, 3'd3);
      9'h034: pos_o = key_at(3'd1, 3'd4);
      9'h015: pos_o = key_at(3'd2, 3'd0);
      9'h01D: pos_o = key_at(3'd2, 3'd1);
      9'h024: pos_o = key_at(3'd2, 3'd2);
      9'h02D: pos_o = key_at(3'd2, 3'd3);
      9'h02C: pos_o = key_at(3'd2, 3'd4);
      9'h016: pos_o = key_at(3'd3, 3'd0);
      9'h01E: pos_o = key_at(3'd3, 3'd1);
      9'h026: pos_o = key_at(3'd3, 3'd2);
      9'h025: pos_o = key_at(3'd3, 3'd3);
      9'h02E: pos_o = key_at(3'd3, 3'd4);
      9'h045: pos_o = key_at(3'd4, 3'd0);
      9'h046: pos_o = key_at(3'd4, 3'd1);
      9'h03E: pos_o = key_at(3'd4, 3'd2);
      9'h03D: pos_o = key_at(3'd4, 3'd3);
      9'h036: pos_o = key_at(3'd4, 3'd4);
      9'h04D: pos_o = key_at(3'd5, 3'd0);
      9'h044: pos_o = key_at(3'd5, 3'd1);
      9'h043: pos_o = key_at(3'd5, 3'd2);
      9'h03C: pos_o = key_at(3'd5, 3'd3);
      9'h035: pos_o = key_at(3'd5, 3'd4);
      9'h05A: pos_o = key_at(3'd6, 3'd0);
      9'h04B: pos_o = key_at(3'd6, 3'd1);
      9'h042: pos_o = key_at(3'd6, 3'd2);
      9'h03B: pos_o = key_at(3'd6, 3'd3);
      9'h033: pos_o = key_at(3'd6, 3'd4);
      9'h029: pos_o = key_at(3'd7, 3'd0);
      9'h014: pos_o = key_at(3'd7, 3'd1);
      9'h03A: pos_o = key_at(3'd7, 3'd2);
      9'h031: pos_o = key_at(3'd7, 3'd3);
      9'h032: pos_o = key_at(3'd7, 3'd4);
`ifdef PS2_EXTENDED_KEYS_EN
      9'h16B: pos_o = ext_key_at(3'd3, 3'd4, 3'd0);
      9'h172: pos_o = ext_key_at(3'd4, 3'd4, 3'd1);
      9'h175: pos_o = ext_key_at(3'd4, 3'd3, 3'd2);
      9'h174: pos_o = ext_key_at(3'd4, 3'd2, 3'd3);
      9'h066: pos_o = ext_key_at(3'd4, 3'd0, 3'd4);
`endif
      default: pos_o = '0;
    endcase
  end

endmodule

// File: rtl/ps2_key_matrix.sv
// PS/2 Set-2 scan codes to ZX Spectrum 8x5 key matrix with prefix-decoding FSM.
// PS2_EXTENDED_KEYS_EN adds arrows/Backspace as composite CAPS keys.
module ps2_key_matrix
  import zx_kbd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] scan_code,
  input  logic       scan_code_ready,
  input  logic       scan_code_error,
  input  logic [7:0] addr_hi,
  output logic [4:0] key_row,
  output logic       pressed
);

  kbd_state_t                   state_q, state_d;
  logic [ROWS-1:0][COLS-1:0]    matrix_q, matrix_d;
  logic                         lshift_q, lshift_d;
  logic                         rshift_q, rshift_d;
  logic                         pressed_q;
  logic [EXT_KEYS-1:0]          ext_held;
  logic                         extended, make, apply;
  key_pos_t                     pos;
  logic [ROWS-1:0][COLS-1:0]    eff;
  logic [COLS-1:0]              sel_or;

  ps2_zx_decode u_decode (
    .extended_i  (extended),
    .scan_code_i (scan_code),
    .pos_o       (pos)
  );

  assign extended = (state_q == EXT) || (state_q == EXT_BRK);
  assign make     = (state_q == IDLE) || (state_q == EXT);

`ifdef PS2_EXTENDED_KEYS_EN
  logic [EXT_KEYS-1:0] ext_q, ext_d;
  assign ext_held = ext_q;
`else
  logic unused_ext;
  assign ext_held   = '0;
  assign unused_ext = ^{pos.ext_idx, pos.ext_valid};
`endif

  always_comb begin
    state_d  = state_q;
    matrix_d = matrix_q;
    lshift_d = lshift_q;
    rshift_d = rshift_q;
    apply    = 1'b0;
`ifdef PS2_EXTENDED_KEYS_EN
    ext_d    = ext_q;
`endif
    if (scan_code_error) begin
      state_d = IDLE;
    end else if (scan_code_ready) begin
      if (scan_code inside {SC_BAT_OK, SC_OVR_LO, SC_OVR_HI}) begin
        state_d  = IDLE;
        matrix_d = '0;
        lshift_d = 1'b0;
        rshift_d = 1'b0;
`ifdef PS2_EXTENDED_KEYS_EN
        ext_d    = '0;
`endif
      end else begin
        case (state_q)
          IDLE: begin
            if (scan_code == SC_BREAK)    state_d = BRK;
            else if (scan_code == SC_EXT) state_d = EXT;
            else                          apply   = 1'b1;
          end
          BRK: begin
            apply   = 1'b1;
            state_d = IDLE;
          end
          EXT: begin
            if (scan_code == SC_BREAK) begin
              state_d = EXT_BRK;
            end else begin
              apply   = 1'b1;
              state_d = IDLE;
            end
          end
          default: begin
            apply   = 1'b1;
            state_d = IDLE;
          end
        endcase
        if (apply) begin
          if (!extended && scan_code == SC_LSHIFT) lshift_d = make;
          if (!extended && scan_code == SC_RSHIFT) rshift_d = make;
          if (pos.valid) matrix_d[pos.row][pos.col] = make;
`ifdef PS2_EXTENDED_KEYS_EN
          if (pos.ext_valid) ext_d[pos.ext_idx] = make;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      matrix_q  <= '0;
      lshift_q  <= 1'b0;
      rshift_q  <= 1'b0;
      pressed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      matrix_q  <= matrix_d;
      lshift_q  <= lshift_d;
      rshift_q  <= rshift_d;
      pressed_q <= (|matrix_q) | lshift_q | rshift_q | (|ext_held);
    end
  end

`ifdef PS2_EXTENDED_KEYS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ext_q <= '0;
    else       ext_q <= ext_d;
  end
`endif

  // CAPS is derived so a composite key release never drops a physically held Shift
  always_comb begin
    eff       = matrix_q;
    eff[0][0] = lshift_q | rshift_q | (|ext_held);
    sel_or    = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (!addr_hi[i]) sel_or = sel_or | eff[i];
    end
    key_row = ~sel_or;
  end

  assign pressed = pressed_q;

endmodule

// File: tb/tb_ps2_key_matrix.sv
// Self-checking bench for ps2_key_matrix: directed cases plus randomized scan-code traffic
// compared every cycle against a behavioural keyboard model.
module tb_ps2_key_matrix;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] scan_code = 8'h00;
  logic       scan_code_ready = 1'b0;
  logic       scan_code_error = 1'b0;
  logic [7:0] addr_hi = 8'hFF;
  logic [4:0] key_row;
  logic       pressed;

  int n_pass  = 0;
  int n_total = 0;
  bit cmp_en  = 1'b0;

  always #5 clk = ~clk;

  ps2_key_matrix dut (
    .clk             (clk),
    .reset           (reset),
    .scan_code       (scan_code),
    .scan_code_ready (scan_code_ready),
    .scan_code_error (scan_code_error),
    .addr_hi         (addr_hi),
    .key_row         (key_row),
    .pressed         (pressed)
  );

  // Spectrum layout: row r holds CAPS/Z/X/C/V, A..G, Q..T, 1..5, 0..6, P..Y, ENT..H, SPC..B
  logic [7:0] keymap [8][5] = '{
    '{8'h00, 8'h1A, 8'h22, 8'h21, 8'h2A},
    '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34},
    '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C},
    '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E},
    '{8'h45, 8'h46, 8'h3E, 8'h3D, 8'h36},
    '{8'h4D, 8'h44, 8'h43, 8'h3C, 8'h35},
    '{8'h5A, 8'h4B, 8'h42, 8'h3B, 8'h33},
    '{8'h29, 8'h14, 8'h3A, 8'h31, 8'h32}
  };
  logic [8:0] ext_code [5] = '{9'h16B, 9'h172, 9'h175, 9'h174, 9'h066};
  int         ext_row  [5] = '{3, 4, 4, 4, 4};
  int         ext_col  [5] = '{4, 4, 3, 2, 0};

  logic [4:0] m_mat [8];
  bit         m_lsh, m_rsh;
  bit [4:0]   m_ext;
  bit         m_e0, m_f0;
  bit         m_pressed;

  function automatic bit m_caps();
    return m_lsh | m_rsh | (|m_ext);
  endfunction

  function automatic bit m_any();
    bit a;
    a = m_caps();
    for (int r = 0; r < 8; r++) a = a | (|m_mat[r]);
    return a;
  endfunction

  function automatic logic [4:0] m_key_row(input logic [7:0] a);
    logic [4:0] res;
    res = 5'h1F;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 5; c++)
        if (!a[r] && (m_mat[r][c] || (r == 0 && c == 0 && m_caps()))) res[c] = 1'b0;
    return res;
  endfunction

  task automatic m_clear();
    for (int r = 0; r < 8; r++) m_mat[r] = 5'h00;
    m_lsh = 1'b0; m_rsh = 1'b0; m_ext = 5'h00;
  endtask

  task automatic m_act(input bit ext, input bit mk, input logic [7:0] b);
    if (!ext && b == 8'h12) m_lsh = mk;
    if (!ext && b == 8'h59) m_rsh = mk;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 5; c++)
        if (!ext && !(r == 0 && c == 0) && keymap[r][c] == b) m_mat[r][c] = mk;
`ifdef PS2_EXTENDED_KEYS_EN
    for (int k = 0; k < 5; k++)
      if ({ext, b} == ext_code[k]) begin
        m_mat[ext_row[k]][ext_col[k]] = mk;
        m_ext[k] = mk;
      end
`endif
  endtask

  task automatic m_byte(input logic [7:0] b);
    if (b == 8'hAA || b == 8'h00 || b == 8'hFF) begin
      m_clear(); m_e0 = 1'b0; m_f0 = 1'b0;
    end else if (b == 8'hF0 && !m_f0) begin
      m_f0 = 1'b1;
    end else if (b == 8'hE0 && !m_e0 && !m_f0) begin
      m_e0 = 1'b1;
    end else begin
      m_act(m_e0, !m_f0, b);
      m_e0 = 1'b0; m_f0 = 1'b0;
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_clear(); m_e0 = 1'b0; m_f0 = 1'b0; m_pressed = 1'b0;
    end else begin
      m_pressed = m_any();
      if (scan_code_error) begin
        m_e0 = 1'b0; m_f0 = 1'b0;
      end else if (scan_code_ready) begin
        m_byte(scan_code);
      end
    end
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("key_row_vs_model", 8'(key_row), 8'(m_key_row(addr_hi)));
      check("pressed_vs_model", 8'(pressed), 8'(m_pressed));
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk); #1;
    scan_code = b; scan_code_ready = 1'b1; scan_code_error = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk); #1;
      scan_code_ready = 1'b0; scan_code_error = 1'b0;
    end
  endtask

  task automatic err_pulse(input bit with_ready, input logic [7:0] b);
    @(negedge clk); #1;
    scan_code = b; scan_code_ready = with_ready; scan_code_error = 1'b1;
  endtask

  task automatic lit(input string name, input logic [7:0] a, input logic [4:0] exp);
    addr_hi = a; #1;
    check(name, 8'(key_row), 8'(exp));
    check({name, "_model"}, 8'(m_key_row(a)), 8'(exp));
  endtask

  function automatic logic [7:0] pick_code();
    int r, rr, cc;
    r = $urandom_range(0, 99);
    if (r < 15) return 8'hF0;
    if (r < 25) return 8'hE0;
    if (r < 28) return ($urandom_range(0, 1) == 0) ? 8'h12 : 8'h59;
    if (r < 33) begin
      case ($urandom_range(0, 4))
        0: return 8'h6B;
        1: return 8'h72;
        2: return 8'h75;
        3: return 8'h74;
        default: return 8'h66;
      endcase
    end
    if (r == 33) return 8'hAA;
    if (r == 34) return ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
    if (r < 92) begin
      rr = $urandom_range(0, 7);
      cc = $urandom_range(0, 4);
      return (rr == 0 && cc == 0) ? 8'h1A : keymap[rr][cc];
    end
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    cmp_en = 1'b1;
    lit("reset_row_all", 8'h00, 5'h1F);
    check("reset_pressed", 8'(pressed), 8'h00);
    reset = 1'b0;

    send(8'h1C); idle(1);
    lit("a_make", 8'hFD, 5'h1E);
    check("pressed_lag", 8'(pressed), 8'h00);
    idle(1);
    check("pressed_set", 8'(pressed), 8'h01);
    send(8'hF0); send(8'h1C); idle(1);
    lit("a_break", 8'hFD, 5'h1F);

    send(8'h12); send(8'h5A); idle(1);
    lit("shift_row0", 8'hFE, 5'h1E);
    lit("enter_row6", 8'hBF, 5'h1E);
    lit("row0_row6", 8'hBE, 5'h1E);
    lit("row7_clear", 8'h7F, 5'h1F);
    send(8'hF0); send(8'h12); send(8'hF0); send(8'h5A); idle(1);
    lit("shift_enter_rel", 8'h00, 5'h1F);

`ifdef PS2_EXTENDED_KEYS_EN
    send(8'h12); send(8'hE0); send(8'h6B); idle(1);
    lit("left_caps", 8'hFE, 5'h1E);
    lit("left_digit5", 8'hF7, 5'h0F);
    send(8'hE0); send(8'hF0); send(8'h6B); idle(1);
    lit("left_rel_caps", 8'hFE, 5'h1E);
    lit("left_rel_digit", 8'hF7, 5'h1F);
    send(8'hF0); send(8'h12); idle(1);
    lit("shift_rel", 8'hFE, 5'h1F);
`endif

    send(8'hF0); err_pulse(1'b0, 8'h00); send(8'h1C); idle(1);
    lit("err_clears_brk", 8'hFD, 5'h1E);
    send(8'hE0); send(8'hF0); send(8'h1C); idle(1);
    lit("ext_brk_unmapped", 8'hFD, 5'h1E);
    send(8'hF0); err_pulse(1'b1, 8'h1C); idle(1);
    lit("err_wins_ready", 8'hFD, 5'h1E);
    send(8'hF0); send(8'h1C); idle(1);
    lit("a_rel_again", 8'hFD, 5'h1F);

    send(8'h29); send(8'h16); idle(1);
    lit("space_one", 8'h77, 5'h1E);
    send(8'hAA); idle(1);
    lit("bat_clear", 8'h00, 5'h1F);
    check("bat_pressed_lag", 8'(pressed), 8'h01);
    idle(1);
    check("bat_pressed_drop", 8'(pressed), 8'h00);

    send(8'hE0); idle(1);
    @(negedge clk); #1; reset = 1'b1;
    idle(2);
    reset = 1'b0;
    send(8'h1C); idle(1);
    lit("reset_drops_e0", 8'hFD, 5'h1E);
    send(8'hF0); send(8'h1C); idle(1);

    for (int i = 0; i < 4000; i++) begin
      int r;
      @(negedge clk); #1;
      r = $urandom_range(0, 99);
      scan_code_ready = 1'b0;
      scan_code_error = 1'b0;
      reset = (r == 50);
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0: addr_hi = 8'h00;
          1: addr_hi = 8'($urandom_range(0, 255));
          default: addr_hi = ~(8'h01 << $urandom_range(0, 7));
        endcase
      end
      if (r < 45) begin
        scan_code_ready = 1'b1; scan_code = pick_code();
      end else if (r < 48) begin
        scan_code_error = 1'b1;
      end else if (r < 50) begin
        scan_code_error = 1'b1; scan_code_ready = 1'b1; scan_code = pick_code();
      end
    end
    reset = 1'b0;
    idle(3);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ps2_key_matrix.md
# ps2_key_matrix

Converts PS/2 Set-2 scan codes into the 8×5 ZX Spectrum keyboard matrix. It sits between `ps2_keyboard`, which delivers scan-code bytes, and the ULA port-0xFE read path, which consumes `key_row[4:0]`. A prefix-decoding state machine maintains a held-key bitmap. The selected half-rows are ANDed (active-low) against the high address byte, matching Spectrum hardware.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  system clock, same domain as `ps2_keyboard` (CPU clock).
- `reset`  in  1  asynchronous, active-high reset.
- `scan_code`  in  8  byte from `ps2_keyboard`; valid only while `scan_code_ready` is high.
- `scan_code_ready`  in  1  single-cycle strobe, one per received byte.
- `scan_code_error`  in  1  single-cycle strobe on a parity or framing error.
- `addr_hi`  in  8  CPU address A[15:8], used as half-row select (bit i = 0 selects row i).
- `key_row`  out  5  active-low column data; 1 = not pressed.
- `pressed`  out  1  high while any matrix key is held.

## Operation
- State: `matrix[8][5]`, internally 1 = held. `shift_held` (L/R Shift). `ext_held[4:0]` (extended keys needing CAPS).
- FSM states: `IDLE`, `BRK` (F0 seen), `EXT` (E0 seen), `EXT_BRK` (E0 F0 seen). It acts only on `scan_code_ready`.
  - `IDLE`: F0 → `BRK`; E0 → `EXT`; any other code is a make; stay `IDLE`.
  - `BRK`: any code is a break of that code → `IDLE`.
  - `EXT`: F0 → `EXT_BRK`; any other code is an extended make → `IDLE`.
  - `EXT_BRK`: any code is an extended break → `IDLE`.
- Make sets the mapped matrix bit. Break clears it. Unmapped codes change nothing but still advance the FSM.
- Map (row/bit):
  - L Shift 0x12 and R Shift 0x59 → `shift_held` (feeds CAPS, row0 bit0).
  - Z 0x1A → row0 bit1.
  - A 0x1C → row1 bit0.
  - 1 0x16 → row3 bit0.
  - 0 0x45 → row4 bit0.
  - Enter 0x5A → row6 bit0.
  - Space 0x29 → row7 bit0.
  - L Ctrl 0x14 → SYMBOL SHIFT, row7 bit1.
  - All remaining letters and digits follow the standard Spectrum layout.
- CAPS SHIFT (row0 bit0) is never stored directly. It is derived as `shift_held | (|ext_held)`, so releasing a composite key does not drop a physically held Shift.
- `shift_held` tracks L and R Shift separately: two flags, ORed.
- 0xAA (BAT complete) or 0x00/0xFF (overrun) in any state: clear the whole matrix, `shift_held` and `ext_held`; FSM → `IDLE`.
- `scan_code_error`: FSM → `IDLE`; matrix unchanged. If it coincides with `scan_code_ready`, the error wins and the byte is dropped.
- `key_row[j] = ~OR_i( ~addr_hi[i] & eff[i][j] )`, where `eff` is the matrix with the derived CAPS bit. With `addr_hi` = 0xFF, `key_row` = 5'h1F.

## Timing
- Reset (asynchronous): matrix, `shift_held`, `ext_held` = 0; FSM = `IDLE`. `key_row` = 5'h1F; `pressed` = 0.
- Matrix updates on the rising edge at which `scan_code_ready` is sampled high, with 1-cycle latency.
- `key_row` is combinational from the registered matrix and `addr_hi`, with no extra delay. This lets the CPU IO read settle within its cycle.
- `pressed` is registered from the matrix, one cycle after the matrix changes.
- Back-to-back strobes on consecutive cycles must each be processed.
- A reset asserted mid-prefix (e.g. after E0) discards the prefix.

## Configuration
- `PS2_EXTENDED_KEYS_EN` defined: extended keys map to composite CAPS combinations.
  - E0 6B ← → CAPS+5 (row3 bit4).
  - E0 72 ↓ → CAPS+6 (row4 bit4).
  - E0 75 ↑ → CAPS+7 (row4 bit3).
  - E0 74 → → CAPS+8 (row4 bit2).
  - Backspace 0x66 (not extended) → CAPS+0 (row4 bit0).
  - Each key sets or clears its own `ext_held` bit together with its digit bit.
- `PS2_EXTENDED_KEYS_EN` undefined:
  - These codes are unmapped and `ext_held` is tied to 0.
  - E0 prefixes are still parsed, so E0 F0 xx sequences do not corrupt state.

## Structure
- Package `zx_kbd_pkg` holds:
  - The FSM state enum.
  - Scan-code constants (F0, E0, AA).
  - A `key_pos_t` struct: `valid`, `row[2:0]`, `col[2:0]`, `ext_idx[2:0]`, `ext_valid`.
- Sub-module `ps2_zx_decode` is a purely combinational lookup: `{extended, scan_code}` → `key_pos_t`.
- Top-level `ps2_key_matrix` holds the FSM, the bitmaps and the row-select logic.

## Test plan
- Reset, then `addr_hi` = 0x00 → `key_row` = 5'h1F and `pressed` = 0.
- Send 1C, then `addr_hi` = 0xFD → `key_row` = 5'h1E and `pressed` = 1 one cycle later. Send F0 1C → `key_row` = 5'h1F.
- Send 12 (Shift), then 5A (Enter). `addr_hi` = 0xFE → 5'h1E; `addr_hi` = 0xBF → 5'h1E; `addr_hi` = 0xBE → 5'h1E. `addr_hi` = 0x7F → 5'h1F.
- With `PS2_EXTENDED_KEYS_EN` defined: send 12, then E0 6B, then E0 F0 6B. `addr_hi` = 0xFE stays 5'h1E throughout, because Shift is still held. `addr_hi` = 0xF7 shows 5'h0F only while the arrow is held.
- Send F0, then pulse `scan_code_error`, then 1C → treated as a make: row1 bit0 is set, not cleared.
- Hold 29 and 16, then send AA → all rows read 5'h1F and `pressed` drops to 0 after 1 cycle.
